// File: rtl/carryselect_pkg.sv
// Shared definitions for the carry-select datapath: slice width, FSM encoding
// and a helper that sizes the nibble counter.
package carryselect_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cs_slice4.sv
// Combinational 4-bit carry-select slice: both ripple sums are formed up front
// and the incoming carry only drives the final mux.
module cs_slice4
  import carryselect_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] s,
  output logic               c_out
);

  logic [SLICE_W-1:0] s0, s1;
  logic [SLICE_W:0]   c0, c1;

  // NOTE: combinational blocks use blocking '=' so each bit sees the carry
  // computed just above it; only clocked blocks use '<='.
  always_comb begin
    s0    = '0;
    s1    = '0;
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < SLICE_W; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign s     = c_in ? s1 : s0;
  assign c_out = c_in ? c1[SLICE_W] : c0[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one 4-bit carry-select slice reused once per
// nibble, with a registered carry chain and a valid/ready wrapper.
module nibble_serial_adder
  import carryselect_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_c;
  logic               last_nib;

  assign slice_a  = a_q[cnt_q*SLICE_W +: SLICE_W];
  assign slice_b  = b_q[cnt_q*SLICE_W +: SLICE_W];
  assign last_nib = (cnt_q == LAST_NIB);

  cs_slice4 u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The unused encoding 2'd3 falls into default and recovers to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ADD;
      ADD:     if (last_nib) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // NOTE: every _d takes its hold value first, so no branch can leave a latch.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      ADD: begin
        sum_d[cnt_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_c;
        if (last_nib) cout_d = slice_c;
        else          cnt_d  = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed vectors, backpressure,
// reset mid-operation and a randomized handshake stream against a+b+cin.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;
  localparam int N_RAND = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, cout;
  logic         out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++;
    if ({cout, sum} !== {1'b0, {W{1'b0}}}) begin
      n_fail++; $display("FAIL reset sum/cout: got %b/%h want 0/0000", cout, sum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full transaction from IDLE: checks capture, exact latency, result, release.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input string name);
    logic [W:0] expv;
    int lat;
    expv = ref_add(ta, tb_, tc);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle in_ready: got %b want 1", name, in_ready); end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = ~tc;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s busy in_ready: got %b want 0", name, in_ready); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != NIB) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, NIB); end
    n_checks++;
    if ({cout, sum} !== expv) begin
      n_fail++; $display("FAIL %s result: got %b/%h want %b/%h", name, cout, sum, expv[W], expv[W-1:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    do_op(16'h0003, 16'h000A, 1'b0, "add_small");
    do_op(16'hFFFF, 16'h0001, 1'b0, "carry_ripple");
    do_op(16'h0001, 16'h000B, 1'b1, "cin_a");
    do_op(16'h0003, 16'h000E, 1'b1, "cin_b");
  endtask

  task automatic test_backpressure();
    logic [W:0] expv;
    int lat;
    expv = ref_add(16'h7FFF, 16'h8000, 1'b1);
    a = 16'h7FFF; b = 16'h8000; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp timeout: out_valid never rose"); end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        in_valid = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp hold %0d: got out_valid=%b in_ready=%b want 1/0", k, out_valid, in_ready);
      end
      n_checks++;
      if ({cout, sum} !== expv) begin
        n_fail++; $display("FAIL bp stable %0d: got %b/%h want %b/%h", k, cout, sum, expv[W], expv[W-1:0]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp stray accept: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum !== {W{1'b0}} || cout !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset clear: got out_valid=%b sum=%h cout=%b want 0/0000/0", out_valid, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    do_op(16'h1111, 16'h2222, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic [W:0] exp_q[$];
    logic [W:0] expv;
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    bit acc_pending = 1'b0;
    in_valid = 1'b0;
    while (recv < N_RAND && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc_pending) begin
        in_valid    = 1'b0;
        acc_pending = 1'b0;
      end
      if (!in_valid) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
        if (sent < N_RAND && $urandom_range(0, 3) != 0) in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready === 1'b1 && out_valid === 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL rand exclusive: in_ready and out_valid both high at cycle %0d", cyc);
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(ref_add(a, b, cin));
        sent++;
        acc_pending = 1'b1;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand duplicate: result %b/%h with nothing outstanding", cout, sum);
        end else begin
          expv = exp_q.pop_front();
          if ({cout, sum} !== expv) begin
            n_fail++;
            $display("FAIL rand txn %0d: got %b/%h want %b/%h", recv, cout, sum, expv[W], expv[W-1:0]);
          end
        end
        recv++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (sent != N_RAND || recv != N_RAND || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand count: sent=%0d recv=%0d left=%0d want %0d/%0d/0", sent, recv, exp_q.size(), N_RAND, N_RAND);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that feeds a 4-bit carry-select slice one nibble per cycle and chains the carry in a register. It sits directly upstream of the 4-bit carry-select adder datapath and wraps it with a valid/ready front end. The result is a WIDTH-bit sum plus carry-out for operand widths the single slice cannot cover.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4, minimum 4
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into nibble 0
- out_valid  output  1  sum/cout valid; held until consumed
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  registered sum
- cout  output  1  carry out of the most significant nibble

## Operation
- Reset values, applied immediately on rst rising and held while rst=1:
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, nibble counter=0, carry register=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b and cin (carry register←cin), clear counter, and go to ADD.
  - ADD: each cycle, the slice adds a[4i+3:4i], b[4i+3:4i] and the carry register, where i is the counter.
    - sum[4i+3:4i] ← slice sum; carry register ← slice carry; counter ← i+1.
    - When i=NIBBLES-1 (NIBBLES=WIDTH/4), cout ← slice carry and go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE. sum and cout stay stable until the next accept.
- Arithmetic:
  - {cout,sum} = a + b + cin, exact modulo 2^(WIDTH+1). No overflow flag.
  - The counter is ceil(log2(NIBBLES)) bits wide, minimum 1. It never wraps past NIBBLES-1.
- Input changes on a/b/cin outside the accept handshake are ignored; operands are captured.
- in_valid while busy: ignored, with no side effect. The upstream holds the operands because in_ready=0.
- out_ready while not DONE: ignored.
- Reset mid-ADD or mid-DONE:
  - The operation is abandoned with no partial result visible.
  - out_valid goes to 0 asynchronously. The next cycle after reset deasserts, the block is in IDLE.

## Timing
- Accept edge T0 (in_valid&in_ready sampled high).
- Nibble i is computed in the cycle after edge T0+i and registered at edge T0+i+1.
- out_valid rises after edge T0+NIBBLES. Latency is NIBBLES cycles, i.e. 4 for WIDTH=16.
- DONE→IDLE on the out_ready edge. in_ready rises the following cycle.
  - Minimum issue interval: NIBBLES+2 cycles with out_ready tied high.
- The IDLE→ADD transition and out_valid are never simultaneous. in_ready and out_valid are never both 1.
- sum and cout are register outputs. Slice outputs are combinational within one cycle.

## Structure
- Shared package carryselect_pkg holds:
  - SLICE_W=4;
  - state encoding IDLE=2'd0, ADD=2'd1, DONE=2'd2;
  - 2'd3 is illegal and recovers to IDLE.
- One sub-module, cs_slice4: a combinational 4-bit carry-select slice.
  - Two ripple sums, one precomputed with carry 0 and one with carry 1, muxed by the incoming carry.
  - Ports a[3:0], b[3:0], c_in, s[3:0], c_out.
- The top level holds the FSM, counter, operand registers, carry register and output registers.
- The nibble select is an indexed part-select on the captured operands.

## Test plan
- Reset, then accept a=16'h0003, b=16'h000A, cin=0 → out_valid after exactly 4 cycles, sum=16'h000D, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, which confirms the carry ripples through all four nibbles.
- a=16'h0001, b=16'h000B, cin=1 → sum=16'h000D, cout=0. Then a=16'h0003, b=16'h000E, cin=1 → sum=16'h0012, cout=0.
- Backpressure: result a=16'h7FFF, b=16'h8000, cin=1 → sum=16'h0000, cout=1.
  - With out_ready held low for 5 cycles, out_valid, sum and cout stay stable and in_ready stays 0.
  - A new in_valid pulse during that window is not accepted.
- Reset mid-operation: assert rst for 1 cycle two cycles after accepting a=16'h1234, b=16'h4321.
  - out_valid=0 and sum=0 at once; in_ready=1 after release.
  - A following add of 16'h1111+16'h2222 returns 16'h3333 with cout=0.
- Random: 200 back-to-back handshakes with random out_ready stalls; every result must match the reference model a+b+cin, with no lost or duplicated transactions.
